// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and constants for the writeback register file
package wb_regfile_pkg;

  localparam int          REG_DATA_BUS  = 32;
  localparam int          REG_ADDR_BUS  = 5;
  localparam logic [31:0] ZEROWORD      = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [3:0]  DBG_WEN_ALL   = 4'hF;

endpackage

// File: rtl/wb_bypass_mux.sv
// rtl/wb_bypass_mux.sv - priority read mux for one GPR port with write-to-read bypass
module wb_bypass_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) (
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // Reset, disabled port and r0 all read zero; a matching in-flight write beats storage.
  always_comb begin
    rd_data_o = '0;
    if (rst_i == RST_ENABLE) begin
      rd_data_o = '0;
    end else if (rd_en_i == WRITE_DISABLE) begin
      rd_data_o = '0;
    end else if (rd_addr_i == ADDR_W'(NOP_REG_ADDR)) begin
      rd_data_o = '0;
    end else if (wr_en_i == WRITE_ENABLE && wr_addr_i == rd_addr_i) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = reg_data_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32x32 GPR file plus HI/LO with bypassed reads and commit trace
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_BUS,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write_en,
  input  logic [ADDR_W-1:0] wb_reg_write_addr,
  input  logic [DATA_W-1:0] wb_reg_write_data,
  input  logic              wb_hilo_write_en,
  input  logic [DATA_W-1:0] wb_hi_write_data,
  input  logic [DATA_W-1:0] wb_lo_write_data,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  output logic [3:0]        dbg_wb_rf_wen,
  output logic [ADDR_W-1:0] dbg_wb_rf_wnum,
  output logic [DATA_W-1:0] dbg_wb_rf_wdata,
  output logic [31:0]       dbg_commit_cnt
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [3:0]        trace_wen_q;
  logic [ADDR_W-1:0] trace_wnum_q;
  logic [DATA_W-1:0] trace_wdata_q;
  logic [31:0]       commit_cnt_q;
  logic [31:0]       commit_cnt_d;
  logic              gpr_commit;

  // A GPR write only commits when enabled and not aimed at the hardwired-zero r0.
  assign gpr_commit   = (wb_reg_write_en == WRITE_ENABLE) &&
                        (wb_reg_write_addr != ADDR_W'(NOP_REG_ADDR));
  assign commit_cnt_d = gpr_commit ? commit_cnt_q + 32'd1 : commit_cnt_q;

  // GPR storage; r0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (gpr_commit) begin
      regs_q[wb_reg_write_addr] <= wb_reg_write_data;
    end
  end

  // HI/LO are always written as a pair, independent of the GPR write.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_hilo_write_en == WRITE_ENABLE) begin
      hi_q <= wb_hi_write_data;
      lo_q <= wb_lo_write_data;
    end
  end

  // Commit trace lags the WB bundle by one cycle; address/data are captured even for bubbles.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      trace_wen_q   <= 4'h0;
      trace_wnum_q  <= '0;
      trace_wdata_q <= '0;
      commit_cnt_q  <= 32'd0;
    end else begin
      trace_wen_q   <= gpr_commit ? DBG_WEN_ALL : 4'h0;
      trace_wnum_q  <= wb_reg_write_addr;
      trace_wdata_q <= wb_reg_write_data;
      commit_cnt_q  <= commit_cnt_d;
    end
  end

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1_mux (
    .rst_i      (rst),
    .rd_en_i    (rd1_en),
    .rd_addr_i  (rd1_addr),
    .wr_en_i    (wb_reg_write_en),
    .wr_addr_i  (wb_reg_write_addr),
    .wr_data_i  (wb_reg_write_data),
    .reg_data_i (regs_q[rd1_addr]),
    .rd_data_o  (rd1_data)
  );

  wb_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2_mux (
    .rst_i      (rst),
    .rd_en_i    (rd2_en),
    .rd_addr_i  (rd2_addr),
    .wr_en_i    (wb_reg_write_en),
    .wr_addr_i  (wb_reg_write_addr),
    .wr_data_i  (wb_reg_write_data),
    .reg_data_i (regs_q[rd2_addr]),
    .rd_data_o  (rd2_data)
  );

  // HI/LO reads forward the incoming pair while it is being written.
  always_comb begin
    hi_rdata = hi_q;
    lo_rdata = lo_q;
    if (rst == RST_ENABLE) begin
      hi_rdata = '0;
      lo_rdata = '0;
    end else if (wb_hilo_write_en == WRITE_ENABLE) begin
      hi_rdata = wb_hi_write_data;
      lo_rdata = wb_lo_write_data;
    end
  end

  assign dbg_wb_rf_wen   = trace_wen_q;
  assign dbg_wb_rf_wnum  = trace_wnum_q;
  assign dbg_wb_rf_wdata = trace_wdata_q;
  assign dbg_commit_cnt  = commit_cnt_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural state sink for the writeback stage: 32x32 general register file plus HI/LO registers.
- Consumes the WB-stage write bundle that the MEM/WB pipeline register produces.
- Serves the decode stage with two GPR read ports and one HI/LO read port, with same-cycle write-to-read bypass.
- Emits a registered commit trace (debug writeback port) and a commit counter for the SoC test harness.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of GPRs (must equal 2**ADDR_W)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_reg_write_en  in  1  GPR write enable from WB
- wb_reg_write_addr  in  ADDR_W  GPR write address
- wb_reg_write_data  in  DATA_W  GPR write data
- wb_hilo_write_en  in  1  HI/LO write enable (writes both)
- wb_hi_write_data  in  DATA_W  HI write data
- wb_lo_write_data  in  DATA_W  LO write data
- rd1_en  in  1  read port 1 enable
- rd1_addr  in  ADDR_W  read port 1 address
- rd1_data  out  DATA_W  read port 1 data (combinational)
- rd2_en  in  1  read port 2 enable
- rd2_addr  in  ADDR_W  read port 2 address
- rd2_data  out  DATA_W  read port 2 data (combinational)
- hi_rdata  out  DATA_W  current HI (combinational, bypassed)
- lo_rdata  out  DATA_W  current LO (combinational, bypassed)
- dbg_wb_rf_wen  out  4  trace byte-enable, 4'hF on a committed GPR write, else 4'h0
- dbg_wb_rf_wnum  out  ADDR_W  trace write address
- dbg_wb_rf_wdata  out  DATA_W  trace write data
- dbg_commit_cnt  out  32  count of committed GPR writes

Behaviour:
- Reset (rst=1 at posedge clk):
  - all GPRs, HI, LO cleared to 0.
  - dbg_wb_rf_wen=0, dbg_wb_rf_wnum=0, dbg_wb_rf_wdata=0, dbg_commit_cnt=0.
  - While rst is high, rd1_data, rd2_data, hi_rdata and lo_rdata are forced to 0 combinationally.
  - Writes presented in a reset cycle are discarded.
  - Reset asserted mid-stream wins over any concurrent write.
- GPR write:
  - At posedge with wb_reg_write_en=1 and wb_reg_write_addr!=0, reg[addr] <= wb_reg_write_data.
  - Writes to addr 0 are dropped; reg0 reads 0 always.
  - Latency: visible in storage on the next cycle. Visible on read ports in the same cycle via bypass.
- GPR read, evaluated in priority order for each port independently:
  1. rst=1 -> 0.
  2. rdN_en=0 -> 0.
  3. rdN_addr==0 -> 0.
  4. wb_reg_write_en=1 and wb_reg_write_addr==rdN_addr -> wb_reg_write_data (bypass).
  5. Otherwise -> reg[rdN_addr].
  - Both ports may read the same address, including a bypassed one.
- HI/LO:
  - At posedge with wb_hilo_write_en=1, HI <= wb_hi_write_data and LO <= wb_lo_write_data.
  - hi_rdata/lo_rdata return the incoming write data when wb_hilo_write_en=1, otherwise the stored values.
- Commit trace, one-cycle registered latency:
  - Each non-reset posedge loads dbg_wb_rf_wen <= (wb_reg_write_en && addr!=0) ? 4'hF : 4'h0.
  - dbg_wb_rf_wnum <= wb_reg_write_addr, dbg_wb_rf_wdata <= wb_reg_write_data, loaded unconditionally.
  - dbg_commit_cnt increments by 1 on each cycle where a GPR write actually commits (en=1, addr!=0). It wraps 0xFFFFFFFF -> 0.
- Bubbles: an all-zero WB bundle (addr 0, en 0) produces no state change, wen=0 trace, and no count.
- Simultaneous GPR and HI/LO writes in one cycle are independent and both commit.

Decomposition:
- Shared package/header:
  - REG_DATA_BUS/REG_ADDR_BUS widths
  - ZEROWORD, NOP_REG_ADDR (0), WRITE_ENABLE/WRITE_DISABLE, RST_ENABLE
  - DBG_WEN_ALL (4'hF)
- One sub-module is natural: wb_bypass_mux, the 4-way priority read mux. Instantiate it twice for the GPR ports. The HI/LO bypass is inline.

Test Plan:
- Reset: preload r5=0x1234 and HI=7, assert rst one cycle -> r5, HI, LO read 0; dbg_commit_cnt=0; dbg_wb_rf_wen=0.
- Write then read: write r3=0xDEADBEEF, next cycle rd1_addr=3 -> 0xDEADBEEF; rd1_en=0 -> 0.
- Bypass: in the same cycle write r7=0xA5A5A5A5 and read rd1=rd2=7 -> both ports 0xA5A5A5A5 combinationally; a prior r7=1 is not returned.
- r0: write r0=0xFFFFFFFF -> rd1_addr=0 reads 0 in the same and next cycle; dbg_wb_rf_wen=0; count unchanged.
- HI/LO: hilo_write_en with HI=0x11, LO=0x22 -> same-cycle hi_rdata=0x11, lo_rdata=0x22; held after en drops. A concurrent GPR write r9=5 also commits.
- Trace/counter: 3 writes (r1, r2, bubble, r4) -> dbg outputs lag one cycle with wen F,F,0,F; dbg_commit_cnt ends at 3. Force the count to 0xFFFFFFFF, commit one write -> 0.
